// File: rtl/djs130_tti_kbd.sv
// djs130_tti_kbd -- DJS130 teletype-input (TTI, device 010 octal) controller.
//
// Receives PS/2 keyboard frames (scan code set 2) and translates make codes to
// 7-bit ASCII. Characters are buffered and handed to the CPU through the
// standard Busy/Done device handshake.
//
// Build option: define TTI_FIFO_EN for a FIFO_DEPTH-entry circular buffer.
// Without it, a single holding register is used.
//
// Ports:
//   clk_204m, rst_n   system clock, asynchronous active-low reset
//   ps2_clk, ps2_data asynchronous PS/2 receive lines
//   i_DIA             data-in-A select (level), drives o_dev_DR combinationally
//   i_KZS / i_KZC     start / clear pulses, one clk_204m cycle each
//   i_mask            interrupt mask for this device
//   o_dev_DR          {8'h00, 1'b0, ascii} while i_DIA=1, else 0
//   o_dev_ZDQQ        interrupt request = Done & ~i_mask
//   o_dev_ZT          {Done, Busy}
//   o_dev_DMs         device code, constant 6'o10
//   o_err             sticky parity / framing / overflow error
//
// Handshake: the decoder presents a character with a one-cycle push strobe;
// the buffer takes it only when not full, otherwise the character is lost
// and o_err is set. There is no back-pressure towards the keyboard.
module djs130_tti_kbd #(
    parameter int FILT_LEN   = 16,
    parameter int TIMEOUT    = 131072,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_204m,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        i_DIA,
    input  logic        i_KZS,
    input  logic        i_KZC,
    input  logic        i_mask,
    output logic [15:0] o_dev_DR,
    output logic        o_dev_ZDQQ,
    output logic [1:0]  o_dev_ZT,
    output logic [5:0]  o_dev_DMs,
    output logic        o_err
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchronizer + stability filter.
    // Reset to the idle-high line level so no false edge follows reset.
    // ------------------------------------------------------------------
    logic [1:0]    clk_sync, dat_sync;
    logic [FW-1:0] clk_cnt, dat_cnt;
    logic          clk_filt, dat_filt, clk_filt_d;
    logic          fall;

    always_ff @(posedge clk_204m or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_cnt    <= '0;
            dat_cnt    <= '0;
            clk_filt   <= 1'b1;
            dat_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_data};
            clk_filt_d <= clk_filt;

            if (clk_sync[1] == clk_filt) begin
                clk_cnt <= '0;
            end else if (clk_cnt == FW'(FILT_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                clk_cnt  <= '0;
            end else begin
                clk_cnt <= clk_cnt + FW'(1);
            end

            if (dat_sync[1] == dat_filt) begin
                dat_cnt <= '0;
            end else if (dat_cnt == FW'(FILT_LEN - 1)) begin
                dat_filt <= dat_sync[1];
                dat_cnt  <= '0;
            end else begin
                dat_cnt <= dat_cnt + FW'(1);
            end
        end
    end

    assign fall = clk_filt_d & ~clk_filt;

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        F_IDLE   = 2'd0,
        F_DATA   = 2'd1,
        F_PARITY = 2'd2,
        F_STOP   = 2'd3
    } frame_state_t;

    frame_state_t  frame_state, frame_next;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_ok;
    logic [TW-1:0] tmo_cnt;
    logic          shift_bit, load_par, rx_done, rx_bad, tmo_hit;
    logic          rx_valid, frame_err;

    always_comb begin
        frame_next = frame_state;
        shift_bit  = 1'b0;
        load_par   = 1'b0;
        rx_done    = 1'b0;
        rx_bad     = 1'b0;
        tmo_hit    = (frame_state != F_IDLE) && !fall &&
                     (tmo_cnt == TW'(TIMEOUT - 1));
        if (tmo_hit) begin
            // Partial frame is dropped silently; o_err is not touched.
            frame_next = F_IDLE;
        end else if (fall) begin
            case (frame_state)
                F_IDLE: begin
                    if (!dat_filt) frame_next = F_DATA;
                end
                F_DATA: begin
                    shift_bit = 1'b1;
                    if (bit_cnt == 3'd7) frame_next = F_PARITY;
                end
                F_PARITY: begin
                    load_par   = 1'b1;
                    frame_next = F_STOP;
                end
                F_STOP: begin
                    frame_next = F_IDLE;
                    if (dat_filt && par_ok) rx_done = 1'b1;
                    else                    rx_bad  = 1'b1;
                end
                default: frame_next = F_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_204m or negedge rst_n) begin
        if (!rst_n) begin
            frame_state <= F_IDLE;
            bit_cnt     <= 3'd0;
            shreg       <= 8'h00;
            par_ok      <= 1'b0;
            tmo_cnt     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_state <= frame_next;
            rx_valid    <= rx_done;
            frame_err   <= rx_bad;
            if (frame_state == F_IDLE || fall) tmo_cnt <= '0;
            else                               tmo_cnt <= tmo_cnt + TW'(1);
            if (fall && frame_state == F_IDLE) bit_cnt <= 3'd0;
            if (shift_bit) begin
                shreg   <= {dat_filt, shreg[7:1]};   // LSB arrives first
                bit_cnt <= bit_cnt + 3'd1;
            end
            // Odd parity: data bits plus parity bit hold an odd number of ones.
            if (load_par) par_ok <= ^{dat_filt, shreg};
        end
    end

    // ------------------------------------------------------------------
    // Scan decoder and translation
    // ------------------------------------------------------------------
    function automatic logic [7:0] xlate(input logic [7:0] code, input logic sh);
        logic [7:0] r;
        r = 8'h00;
        case (code)
            8'h1C: r = 8'hC1; 8'h32: r = 8'hC2; 8'h21: r = 8'hC3; 8'h23: r = 8'hC4;
            8'h24: r = 8'hC5; 8'h2B: r = 8'hC6; 8'h34: r = 8'hC7; 8'h33: r = 8'hC8;
            8'h43: r = 8'hC9; 8'h3B: r = 8'hCA; 8'h42: r = 8'hCB; 8'h4B: r = 8'hCC;
            8'h3A: r = 8'hCD; 8'h31: r = 8'hCE; 8'h44: r = 8'hCF; 8'h4D: r = 8'hD0;
            8'h15: r = 8'hD1; 8'h2D: r = 8'hD2; 8'h1B: r = 8'hD3; 8'h2C: r = 8'hD4;
            8'h3C: r = 8'hD5; 8'h2A: r = 8'hD6; 8'h1D: r = 8'hD7; 8'h22: r = 8'hD8;
            8'h35: r = 8'hD9; 8'h1A: r = 8'hDA;
            8'h45: r = {1'b1, sh ? 7'h29 : 7'h30};
            8'h16: r = {1'b1, sh ? 7'h21 : 7'h31};
            8'h1E: r = {1'b1, sh ? 7'h40 : 7'h32};
            8'h26: r = {1'b1, sh ? 7'h23 : 7'h33};
            8'h25: r = {1'b1, sh ? 7'h24 : 7'h34};
            8'h2E: r = {1'b1, sh ? 7'h25 : 7'h35};
            8'h36: r = {1'b1, sh ? 7'h5E : 7'h36};
            8'h3D: r = {1'b1, sh ? 7'h26 : 7'h37};
            8'h3E: r = {1'b1, sh ? 7'h2A : 7'h38};
            8'h46: r = {1'b1, sh ? 7'h28 : 7'h39};
            8'h29: r = 8'hA0;   // space
            8'h5A: r = 8'h8D;   // enter
            8'h66: r = 8'h88;   // backspace
            8'h76: r = 8'h9B;   // escape
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic       break_pend, ext_pend, shift;
    logic       push;
    logic [6:0] push_char;
    logic [7:0] xl;
    logic       is_shift_code;

    assign xl            = xlate(shreg, shift);
    assign is_shift_code = (shreg == 8'h12) || (shreg == 8'h59);

    always_ff @(posedge clk_204m or negedge rst_n) begin
        if (!rst_n) begin
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
            shift      <= 1'b0;
            push       <= 1'b0;
            push_char  <= 7'h00;
        end else begin
            push <= 1'b0;
            if (rx_valid) begin
                if (shreg == 8'hF0) begin
                    break_pend <= 1'b1;
                end else if (shreg == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else begin
                    // Any other byte completes the pending prefix sequence.
                    break_pend <= 1'b0;
                    ext_pend   <= 1'b0;
                    if (!ext_pend) begin
                        if (is_shift_code) begin
                            shift <= !break_pend;
                        end else if (!break_pend && xl[7]) begin
                            push      <= 1'b1;
                            push_char <= xl[6:0];
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Character buffer
    // ------------------------------------------------------------------
    logic          busy, done, err;
    logic [6:0]    data_reg;
    logic [6:0]    head;
    logic          full, empty, pop, push_ok;
    logic [CW-1:0] buf_count;

    assign empty   = (buf_count == '0);
    assign pop     = busy & ~empty & ~i_KZC & ~i_KZS;
    assign push_ok = push & ~full;

`ifdef TTI_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [6:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk_204m) begin
        if (push_ok) mem[wr_ptr] <= push_char;
    end

    // Power-of-two depth: pointers wrap naturally.
    always_ff @(posedge clk_204m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   buf_count <= buf_count + CW'(1);
                2'b01:   buf_count <= buf_count - CW'(1);
                default: buf_count <= buf_count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
    assign full = (buf_count == CW'(FIFO_DEPTH));
`else
    logic       hold_valid;
    logic [6:0] hold_data;

    // push_ok only happens with the register empty, so it never meets pop.
    always_ff @(posedge clk_204m or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= 7'h00;
        end else begin
            if (pop) hold_valid <= 1'b0;
            if (push_ok) begin
                hold_valid <= 1'b1;
                hold_data  <= push_char;
            end
        end
    end

    assign head      = hold_data;
    assign full      = hold_valid;
    assign buf_count = CW'(hold_valid);
`endif

    // ------------------------------------------------------------------
    // Device flags: KZC over KZS over delivery
    // ------------------------------------------------------------------
    always_ff @(posedge clk_204m or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            data_reg <= 7'h00;
        end else if (i_KZC) begin
            busy <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (i_KZS) begin
                busy <= 1'b1;
                done <= 1'b0;
            end else if (pop) begin
                busy     <= 1'b0;
                done     <= 1'b1;
                data_reg <= head;
            end
            if (frame_err || (push && full)) err <= 1'b1;
        end
    end

    assign o_dev_DR   = i_DIA ? {9'h000, data_reg} : 16'h0000;
    assign o_dev_ZDQQ = done & ~i_mask;
    assign o_dev_ZT   = {done, busy};
    assign o_dev_DMs  = 6'o10;
    assign o_err      = err;

endmodule

// File: tb/tb_djs130_tti_kbd.sv
// tb_djs130_tti_kbd -- bench for djs130_tti_kbd.
// Directed steps plus randomized keystrokes; a behavioural model of the
// keyboard/device rules keeps the expected flags, error bit and character
// queue. Set TTI_FIFO_EN consistently for RTL and bench.
module tb_djs130_tti_kbd;

    localparam int FILT_LEN   = 4;
    localparam int TIMEOUT    = 2000;
    localparam int FIFO_DEPTH = 8;
    localparam int HALF       = 12;
    localparam int LAT_MAX    = 2 + FILT_LEN + 3 + 2;
`ifdef TTI_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif

    // ---------------- clock / reset ----------------
    logic        clk_204m = 1'b0;
    logic        rst_n    = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic        i_DIA    = 1'b0;
    logic        i_KZS    = 1'b0;
    logic        i_KZC    = 1'b0;
    logic        i_mask   = 1'b0;
    logic [15:0] o_dev_DR;
    logic        o_dev_ZDQQ;
    logic [1:0]  o_dev_ZT;
    logic [5:0]  o_dev_DMs;
    logic        o_err;

    always #2 clk_204m = ~clk_204m;

    djs130_tti_kbd #(
        .FILT_LEN  (FILT_LEN),
        .TIMEOUT   (TIMEOUT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_204m  (clk_204m),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .i_DIA     (i_DIA),
        .i_KZS     (i_KZS),
        .i_KZC     (i_KZC),
        .i_mask    (i_mask),
        .o_dev_DR  (o_dev_DR),
        .o_dev_ZDQQ(o_dev_ZDQQ),
        .o_dev_ZT  (o_dev_ZT),
        .o_dev_DMs (o_dev_DMs),
        .o_err     (o_err)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [6:0] exp_q[$];
    logic       m_busy, m_done, m_err, m_shift, m_brk, m_ext;
    logic [6:0] m_data;
    int         n_vec  = 0;
    int         n_fail = 0;
    int         done_lat;

    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                      8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                     8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] digit_sym   [10] = '{")", "!", "@", "#", "$", "%", "^", "&", "*", "("};
    logic [7:0] spec_codes  [4]  = '{8'h29, 8'h5A, 8'h66, 8'h76};
    logic [7:0] spec_ascii  [4]  = '{8'h20, 8'h0D, 8'h08, 8'h1B};

    function automatic logic [7:0] lookup(input logic [7:0] code, input logic sh);
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == code) return {1'b1, 7'("A" + i)};
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == code) return {1'b1, sh ? digit_sym[i][6:0] : 7'("0" + i)};
        for (int i = 0; i < 4; i++)
            if (spec_codes[i] == code) return {1'b1, spec_ascii[i][6:0]};
        return 8'h00;
    endfunction

    function automatic logic [7:0] key_code(input int k);
        if (k < 26) return letter_codes[k];
        if (k < 36) return digit_codes[k - 26];
        if (k < 40) return spec_codes[k - 36];
        if (k == 40) return 8'h05;
        return 8'h0E;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_busy = 0; m_done = 0; m_err = 0;
        m_shift = 0; m_brk = 0; m_ext = 0;
        m_data = 7'h00;
    endtask

    task automatic model_deliver();
        if (m_busy && exp_q.size() > 0) begin
            m_data = exp_q.pop_front();
            m_busy = 0;
            m_done = 1;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] t;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            if (m_ext) begin
            end else if (b == 8'h12 || b == 8'h59) begin
                m_shift = !m_brk;
            end else if (!m_brk) begin
                t = lookup(b, m_shift);
                if (t[7]) begin
                    if (exp_q.size() >= CAP) m_err = 1;
                    else exp_q.push_back(t[6:0]);
                    model_deliver();
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        i_DIA = 1'b0;
        #1;
        check({tag, "_dr_off"}, o_dev_DR, 16'h0000);
        i_DIA = 1'b1;
        #1;
        check({tag, "_dr"}, o_dev_DR, {9'h000, m_data});
        check({tag, "_zt"}, 16'(o_dev_ZT), 16'({m_done, m_busy}));
        check({tag, "_zdqq"}, 16'(o_dev_ZDQQ), 16'(m_done & ~i_mask));
        check({tag, "_err"}, 16'(o_err), 16'(m_err));
        i_DIA = 1'b0;
    endtask

    // ---------------- drivers ----------------
    task automatic send_bits(input logic [10:0] bits, input int n, input bit watch);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk_204m);
            ps2_clk = 1'b0;
            for (int j = 0; j < HALF; j++) begin
                @(negedge clk_204m);
                if (watch && i == n - 1 && done_lat < 0 && o_dev_ZT[1]) done_lat = j + 1;
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk_204m);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        done_lat = -1;
        send_bits(bits, 11, 1'b1);
        if (bad_par || bad_stop) m_err = 1;
        else model_byte(b);
    endtask

    task automatic send_key(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    task automatic kzs();
        @(negedge clk_204m) i_KZS = 1'b1;
        @(negedge clk_204m) i_KZS = 1'b0;
        @(negedge clk_204m);
        m_busy = 1; m_done = 0;
        model_deliver();
    endtask

    task automatic kzc();
        @(negedge clk_204m) i_KZC = 1'b1;
        @(negedge clk_204m) i_KZC = 1'b0;
        m_busy = 0; m_done = 0; m_err = 0;
    endtask

    task automatic read_dr(input string tag, input logic [15:0] expv);
        i_DIA = 1'b1;
        #1;
        check(tag, o_dev_DR, expv);
        i_DIA = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        model_reset();
        repeat (5) @(negedge clk_204m);
        rst_n = 1'b1;
        @(negedge clk_204m);
        check_all("reset");
        check("dms", 16'(o_dev_DMs), 16'h0008);

        // "A" with Busy already set: Done within the latency bound.
        kzs();
        check("kzs_busy", 16'(o_dev_ZT), 16'h0001);
        send_key(8'h1C);
        check("a_latency", 16'(done_lat >= 1 && done_lat <= LAT_MAX), 16'h0001);
        check_all("a_mask0");
        read_dr("a_dr", 16'h0041);

        // Same with interrupt masked, then clear.
        i_mask = 1'b1;
        kzs();
        send_key(8'h1C);
        check_all("a_mask1");
        kzc();
        check_all("a_kzc");
        i_mask = 1'b0;

        // Shifted digit, releases, unshifted digit.
        kzs();
        send_key(8'h12); send_key(8'h16); send_key(8'hF0); send_key(8'h16);
        send_key(8'hF0); send_key(8'h12); send_key(8'h16);
        check_all("shift_first");
        read_dr("shift_dr1", 16'h0021);
        kzs();
        check_all("shift_second");
        read_dr("shift_dr2", 16'h0031);

        // KZS with a buffered character: Busy for exactly one cycle.
        kzc();
        send_key(8'h32);
        @(negedge clk_204m) i_KZS = 1'b1;
        @(negedge clk_204m) i_KZS = 1'b0;
        check("busy_one_cycle", 16'(o_dev_ZT), 16'h0001);
        @(negedge clk_204m);
        check("done_after", 16'(o_dev_ZT), 16'h0002);
        m_busy = 1; m_done = 0;
        model_deliver();
        check_all("b_char");

        // Parity and stop errors.
        kzs();
        send_frame(8'h1C, 1'b1, 1'b0);
        check_all("bad_parity");
        kzc();
        check_all("kzc_err");
        send_frame(8'h24, 1'b0, 1'b1);
        check_all("bad_stop");
        kzc();

        // Partial frame abandoned by timeout.
        kzs();
        send_bits(11'h0AA, 5, 1'b0);
        repeat (TIMEOUT + 10) @(negedge clk_204m);
        send_key(8'h29);
        check_all("timeout_space");
        read_dr("timeout_dr", 16'h0020);

        // Overflow: CAP+1 characters without KZS.
        kzc();
        for (int i = 0; i <= CAP; i++) send_key(letter_codes[i + 2]);
        check_all("overflow");
        for (int i = 0; i < CAP; i++) begin
            kzs();
            check_all("drain");
        end
        kzc();

        // Reset mid-frame with a buffered character.
        send_key(8'h1D);
        send_bits(11'h0F0, 4, 1'b0);
        @(negedge clk_204m) rst_n = 1'b0;
        repeat (3) @(negedge clk_204m);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk_204m);
        check_all("reset_mid");
        kzs();
        check_all("reset_empty");
        send_key(8'h4D);
        check_all("after_reset");

        // Randomized keystrokes.
        for (int it = 0; it < 16; it++) begin
            int         k;
            logic [7:0] sc, shc;
            bit         use_sh, ext;
            use_sh = 1'($urandom_range(0, 1));
            ext    = ($urandom_range(0, 5) == 0);
            k      = int'($urandom_range(0, 41));
            sc     = key_code(k);
            shc    = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
            if (use_sh) send_key(shc);
            if (ext) send_key(8'hE0);
            send_key(sc);
            if (ext) send_key(8'hE0);
            send_key(8'hF0);
            send_key(sc);
            if (use_sh && $urandom_range(0, 3) != 0) begin
                send_key(8'hF0);
                send_key(shc);
            end
            if ($urandom_range(0, 4) == 0) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
            i_mask = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) kzs();
            check_all("rand");
            if (m_err && $urandom_range(0, 1) != 0) kzc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
